// File: rtl/led_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_ramp_sequencer
// Description : Table-driven brightness sequencer for the LED PWM datapath.
//               Steps through N_ENTRIES {target, hold} entries. For each
//               entry the brightness register ramps one LSB per prescaler
//               tick toward the target. It then dwells for hold+1 ticks and
//               advances. At the end of the table it either wraps (loop=1)
//               or returns to idle with a one-cycle done pulse.
// Ports       : sys_clk, sys_rst       - clock, synchronous active-high reset
//               cfg_we/addr/target/hold - table write port, usable any time
//               prescale               - tick period minus 1, captured at start
//               start, stop, loop      - sequence control (stop wins)
//               brightness             - registered level to PWM comparator
//               entry_idx              - table entry currently being played
//               busy                   - sequencer active (state != IDLE)
//               done                   - pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module led_ramp_sequencer #(
    parameter int N_ENTRIES = 4,
    parameter int BW        = 8,
    parameter int DIV_W     = 18
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         cfg_we,
    input  logic [$clog2(N_ENTRIES)-1:0] cfg_addr,
    input  logic [BW-1:0]                cfg_target,
    input  logic [BW-1:0]                cfg_hold,
    input  logic [DIV_W-1:0]             prescale,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    output logic [BW-1:0]                brightness,
    output logic [$clog2(N_ENTRIES)-1:0] entry_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int              c_AW   = $clog2(N_ENTRIES);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [BW-1:0]    r_tgt  [N_ENTRIES];
    logic [BW-1:0]    r_hold [N_ENTRIES];

    logic [DIV_W-1:0] r_prescale;
    logic [DIV_W-1:0] w_prescale_nxt;
    logic [DIV_W-1:0] r_presc_cnt;
    logic [DIV_W-1:0] w_presc_cnt_nxt;
    logic [BW-1:0]    r_brightness;
    logic [BW-1:0]    w_brightness_nxt;
    logic [BW-1:0]    r_hold_cnt;
    logic [BW-1:0]    w_hold_cnt_nxt;
    logic [c_AW-1:0]  r_idx;
    logic [c_AW-1:0]  w_idx_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_busy;
    logic             w_tick;
    logic [BW-1:0]    w_cur_tgt;
    logic [BW-1:0]    w_cur_hold;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_tick     = w_busy && (r_presc_cnt == '0);
    // Reading the table live means a write to the active entry takes effect
    // on the first tick evaluated after the write edge.
    assign w_cur_tgt  = r_tgt[r_idx];
    assign w_cur_hold = r_hold[r_idx];

    // ------------------------------------------------------------------
    // Pattern table
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_tgt[i]  <= '0;
                r_hold[i] <= '0;
            end
        end else if (cfg_we) begin
            r_tgt[cfg_addr]  <= cfg_target;
            r_hold[cfg_addr] <= cfg_hold;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= ST_IDLE;
            r_prescale   <= '0;
            r_presc_cnt  <= '0;
            r_brightness <= '0;
            r_hold_cnt   <= '0;
            r_idx        <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prescale   <= w_prescale_nxt;
            r_presc_cnt  <= w_presc_cnt_nxt;
            r_brightness <= w_brightness_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_prescale_nxt   = r_prescale;
        w_presc_cnt_nxt  = r_presc_cnt;
        w_brightness_nxt = r_brightness;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_idx_nxt        = r_idx;
        w_done_nxt       = 1'b0;

        // Prescaler free-runs while busy; the FSM may override on start.
        if (w_busy) begin
            if (w_tick) begin
                w_presc_cnt_nxt = r_prescale;
            end else begin
                w_presc_cnt_nxt = r_presc_cnt - DIV_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                // Brightness is left alone so a new run ramps from wherever
                // the previous run stopped.
                if (start && !stop) begin
                    w_state_nxt     = ST_RAMP;
                    w_idx_nxt       = '0;
                    w_prescale_nxt  = prescale;
                    w_presc_cnt_nxt = prescale;
                end
            end

            ST_RAMP: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_brightness < w_cur_tgt) begin
                        w_brightness_nxt = r_brightness + BW'(1);
                    end else if (r_brightness > w_cur_tgt) begin
                        w_brightness_nxt = r_brightness - BW'(1);
                    end else begin
                        // Equality is only detected on a tick, so arrival
                        // costs one extra tick before the dwell starts.
                        w_state_nxt    = ST_HOLD;
                        w_hold_cnt_nxt = w_cur_hold;
                    end
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (r_hold_cnt != '0) begin
                        w_hold_cnt_nxt = r_hold_cnt - BW'(1);
                    end else if (r_idx != c_LAST) begin
                        w_idx_nxt   = r_idx + c_AW'(1);
                        w_state_nxt = ST_RAMP;
                    end else if (loop) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_RAMP;
                    end else begin
                        // Index stays on the last entry after completion.
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign brightness = r_brightness;
    assign entry_idx  = r_idx;
    assign busy       = w_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/led_ramp_sequencer.md
Name: led_ramp_sequencer

Overview:
Pattern controller for the LED PWM brightness datapath. Holds a small programmable table of {target brightness, hold time} entries. Steps through the table, ramping an 8-bit brightness register one LSB per prescaler tick toward each target, then dwelling for the programmed time. The brightness output drives the existing PWM comparator (led = pwm_ctr < brightness); this block replaces the free-running triangle sweep with a sequenced, start/stop-controlled one.

Parameters:
N_ENTRIES, 4, number of table entries (power of two, 2..16)
BW, 8, brightness and hold field width
DIV_W, 18, prescaler width

Ports:
sys_clk  in  1  system clock; only clock
sys_rst  in  1  synchronous active-high reset
cfg_we  in  1  table write strobe
cfg_addr  in  log2(N_ENTRIES)  table write index
cfg_target  in  BW  target brightness for written entry
cfg_hold  in  BW  hold ticks for written entry
prescale  in  DIV_W  tick period minus 1; sampled at start
start  in  1  begin sequence at entry 0 (level, sampled each cycle)
stop  in  1  abort to IDLE
loop  in  1  1 = wrap from last entry to entry 0 instead of finishing; read live
brightness  out  BW  registered brightness to PWM datapath
entry_idx  out  log2(N_ENTRIES)  current table index
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse on normal sequence completion

Behaviour:
- Reset (sync, sys_rst=1 at edge): state IDLE, brightness 0, entry_idx 0, busy 0, done 0, presc_cnt 0, hold_cnt 0, all table entries {0,0}. Reset overrides everything, including mid-ramp.
- Table: cfg_we writes {cfg_target, cfg_hold} to entry cfg_addr at the edge; writes are allowed in any state. A write to the active entry is used from the next tick evaluation onward.
- Prescaler: runs only when busy. tick = busy && presc_cnt==0. On tick, presc_cnt <= prescale_reg; otherwise presc_cnt <= presc_cnt-1. Tick period = prescale_reg+1 cycles.
- States: IDLE, RAMP, HOLD.
- IDLE: if start && !stop, then state<=RAMP, entry_idx<=0, prescale_reg<=prescale, presc_cnt<=prescale. First tick falls prescale+1 cycles after the accepting edge. brightness is not modified (ramp starts from the current value).
- RAMP, on tick: brightness<target gives +1; brightness>target gives -1; equal gives state<=HOLD and hold_cnt<=hold. Reaching the target therefore costs one extra tick to detect equality.
- HOLD, on tick: if hold_cnt!=0, decrement; else advance. HOLD lasts hold+1 ticks.
- Advance: if entry_idx != N_ENTRIES-1, entry_idx+1 and state RAMP. Else, if loop, entry_idx<=0 and state RAMP; else state<=IDLE and done<=1 for one cycle, with entry_idx left at the last entry.
- No arithmetic wrap: brightness only moves toward target, so it never under- or overflows (0..2^BW-1).
- stop: in any non-IDLE state, next state IDLE, no done, brightness frozen, entry_idx frozen. stop has priority over start and over a same-cycle tick action.
- start while busy: ignored, no restart.
- done and start in the same cycle: done still pulses; start is sampled in the following cycle (state is IDLE then).
- busy is combinational from the registered state (state!=IDLE). All other outputs are registered.

Test Plan:
1. Reset: assert sys_rst mid-RAMP with brightness=5. Next cycle: brightness 0, busy 0, entry_idx 0, done 0; a following start ramps from 0.
2. Full sequence: prescale=0, loop=0; entries {3,1},{0,0},{0,0},{0,0}; start accepted at edge k. Brightness per tick is 1,2,3,3,3,3,2,1,0,0,0,0,0,0,0 (15 ticks). busy is high for 15 cycles; done is high only in the cycle after edge k+15; entry_idx ends at 3.
3. Prescaler: prescale=3, entry0 {2,0}. Brightness changes 0→1 at edge k+4 and 1→2 at edge k+8, i.e. exactly 4 cycles per step.
4. Loop: loop=1 with the table from scenario 2. After tick 15, entry_idx returns to 0, no done pulse, and brightness ramps 1,2,3 again. Dropping loop during the second pass ends with done after that pass.
5. Stop/start priority: during HOLD, assert stop and start together. Next cycle is IDLE, brightness unchanged, no done. Start alone later restarts at entry 0 from the frozen brightness.
6. Live table write: during RAMP toward entry1 target 0 at brightness 2, write entry1 target=200. Ramp direction reverses on the next tick (2→3), and start pulses while busy have no effect.
